// File: rtl/fetch_sequencer_pkg.sv
// Shared types for the instruction fetch sequencer: FSM states and the buffered fetch entry.
package fetch_sequencer_pkg;

    localparam int unsigned INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_HALTED
    } FetchState;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } FetchEntry;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head reads as zero when empty so idle outputs stay clean.
module fetch_fifo
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type T = FetchEntry
) (
    input  logic                       clk,
    input  logic                       rst_async,
    input  logic                       push,
    input  T                           push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output T                           head
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Pointer/count state; flush discards everything buffered.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

    no_push_when_full: assert property (@(posedge clk) disable iff (rst_async)
        !(push && !flush && (count == CW'(DEPTH))));

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, issues in-order memory requests under a credit limit,
// buffers returned words and handles start/halt/redirect with stale-response dropping.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_async,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        busy
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    FetchState     state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] fifo_count;
    logic [SW-1:0] credit_used;
    logic [31:0]   redirect_base;
    logic          issue, push, pop, drop;
    FetchEntry     push_entry, head_entry;

    assign credit_used   = SW'(outstanding_q) + SW'(fifo_count);
    assign redirect_base = redirect_pc & ~32'(INSTR_BYTES - 1);

    // FSM next state and request qualification; halt beats start.
    always_comb begin
        state_d       = state_q;
        mem_req_valid = 1'b0;
        case (state_q)
            FS_IDLE, FS_HALTED: if (start && !halt) state_d = FS_RUN;
            FS_RUN: begin
                if (halt) state_d = FS_HALTED;
                mem_req_valid = !redirect_valid && (credit_used < SW'(DEPTH));
            end
            default: state_d = FS_IDLE;
        endcase
    end

    // Datapath next values; a redirect writes off every word still in flight.
    always_comb begin
        issue         = mem_req_valid && mem_req_ready;
        drop          = mem_rsp_valid && (drop_cnt_q != '0);
        push          = mem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
        pop           = instr_valid && instr_ready;
        outstanding_d = outstanding_q + CW'(issue) - CW'(mem_rsp_valid);
        drop_cnt_d    = drop_cnt_q;
        pc_d          = pc_q;
        rsp_pc_d      = rsp_pc_q;
        push_entry    = '{pc: rsp_pc_q, word: mem_rsp_data};
        if (redirect_valid) begin
            drop_cnt_d = outstanding_q - CW'(mem_rsp_valid);
            pc_d       = redirect_base;
            rsp_pc_d   = redirect_base;
        end else begin
            if (drop)  drop_cnt_d = drop_cnt_q - CW'(1);
            if (issue) pc_d       = pc_q + 32'(INSTR_BYTES);
            if (push)  rsp_pc_d   = rsp_pc_q + 32'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q       <= FS_IDLE;
            pc_q          <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (FetchEntry)
    ) u_fifo (
        .clk       (clk),
        .rst_async (rst_async),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (fifo_count),
        .head      (head_entry)
    );

    assign mem_req_addr = pc_q;
    assign instr_valid  = (fifo_count != '0) && !redirect_valid;
    assign instruction  = head_entry.word;
    assign instr_pc     = head_entry.pc;
    assign busy         = (outstanding_q != '0) || (fifo_count != '0);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer against a transaction-level model
// (in-flight queue tagged with a redirect epoch, decoder buffer queue, in-order memory).
module tb_fetch_sequencer;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_async;
    logic        start, halt, redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instruction, instr_pc;
    logic        busy;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_async      (rst_async),
        .start          (start),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .busy           (busy)
    );

    typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] word; } ment_t;

    mreq_t       mq[$];
    ment_t       buf_q[$];
    logic [31:0] m_pc;
    bit          running;
    bit          rsp_jitter;
    int          epoch, cyc, lat;
    int          n_chk, n_pass;
    int          dut_req, dut_deliv;
    logic [31:0] first_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0] ^ 16'hC3A5, addr[31:16]} + 32'h1234_5677;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: present memory response, compare at negedge, advance model, land at posedge+1.
    task automatic tick();
        bit    exp_rv, exp_iv;
        mreq_t e;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
        if (mq.size() != 0 && mq[0].due <= cyc && (!rsp_jitter || $urandom_range(3) != 0)) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem_word(mq[0].addr);
        end
        @(negedge clk);
        exp_rv = running && !redirect_valid && (mq.size() + buf_q.size() < DEPTH);
        exp_iv = (buf_q.size() != 0) && !redirect_valid;
        check("req_valid", 64'(mem_req_valid), 64'(exp_rv));
        check("req_addr", 64'(mem_req_addr), 64'(m_pc));
        check("instr_valid", 64'(instr_valid), 64'(exp_iv));
        check("busy", 64'(busy), 64'((mq.size() != 0) || (buf_q.size() != 0)));
        if (exp_iv) check("instr_pc_word", {instr_pc, instruction}, {buf_q[0].pc, buf_q[0].word});
        if (mem_req_valid && mem_req_ready) dut_req++;
        if (instr_valid && instr_ready) begin
            if (dut_deliv == 0) first_pc = instr_pc;
            dut_deliv++;
        end
        if (exp_iv && instr_ready) void'(buf_q.pop_front());
        if (mem_rsp_valid) begin
            e = mq.pop_front();
            if (!redirect_valid && e.epoch == epoch) buf_q.push_back('{e.addr, mem_word(e.addr)});
        end
        if (exp_rv && mem_req_ready) begin
            mq.push_back('{m_pc, epoch, cyc + lat});
            m_pc = m_pc + 32'd4;
        end
        if (redirect_valid) begin
            buf_q.delete();
            m_pc = redirect_pc & ~32'h3;
            epoch++;
        end
        if (halt) running = 1'b0;
        else if (start) running = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        start = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
    endtask

    // Asynchronous reset from wherever we are; memory shares the reset so its queue empties too.
    task automatic apply_reset();
        rst_async = 1'b1;
        start = 1'b0; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0; instr_ready = 1'b0;
        #2;
        check("rst_req_valid", 64'(mem_req_valid), 64'(0));
        check("rst_req_addr", 64'(mem_req_addr), 64'(0));
        check("rst_instr_valid", 64'(instr_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_instruction", 64'(instruction), 64'(0));
        check("rst_instr_pc", 64'(instr_pc), 64'(0));
        mq.delete(); buf_q.delete();
        m_pc = 32'h0; running = 1'b0; rsp_jitter = 1'b0;
        dut_req = 0; dut_deliv = 0; first_pc = 32'h0;
        @(negedge clk);
        rst_async = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic rand_cycle();
        instr_ready   = ($urandom_range(3) != 0);
        mem_req_ready = ($urandom_range(2) != 0);
        start         = ($urandom_range(15) == 0);
        halt          = ($urandom_range(39) == 0);
        if ($urandom_range(29) == 0) begin
            redirect_valid = 1'b1;
            redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                   : 32'($urandom);
        end
        tick();
    endtask

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; epoch = 0; lat = 1;
        apply_reset();

        // 1: streaming at one word per cycle after the fill latency
        lat = 1; mem_req_ready = 1'b1; instr_ready = 1'b1; start = 1'b1;
        tick();
        repeat (11) tick();
        check("t1_deliveries", 64'(dut_deliv), 64'(9));
        check("t1_first_pc", 64'(first_pc), 64'(0));

        // 2: decoder stalled, credit limit caps requests at DEPTH
        apply_reset();
        lat = 1; mem_req_ready = 1'b1; instr_ready = 1'b0; start = 1'b1;
        tick();
        repeat (10) tick();
        check("t2_req_count", 64'(dut_req), 64'(DEPTH));
        check("t2_stalled", 64'(mem_req_valid), 64'(0));
        instr_ready = 1'b1;
        repeat (8) tick();
        check("t2_first_pc", 64'(first_pc), 64'(0));
        check("t2_resumed", 64'(dut_req > 4), 64'(1));

        // 3: redirect with two in flight and one buffered
        apply_reset();
        lat = 3; instr_ready = 1'b0; mem_req_ready = 1'b0; start = 1'b1;
        tick();
        mem_req_ready = 1'b1;
        repeat (3) tick();
        mem_req_ready = 1'b0;
        tick();
        check("t3_buffered", 64'(instr_valid), 64'(1));
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        check("t3_flushed", 64'(instr_valid), 64'(0));
        mem_req_ready = 1'b1; instr_ready = 1'b1;
        for (int i = 0; i < 20 && dut_deliv == 0; i++) tick();
        check("t3_first_pc", 64'(first_pc), 64'(32'h100));

        // 4: halt with two outstanding, drain, then resume sequentially
        apply_reset();
        lat = 2; instr_ready = 1'b0; mem_req_ready = 1'b1; start = 1'b1;
        tick();
        tick();
        halt = 1'b1;
        tick();
        instr_ready = 1'b1;
        for (int i = 0; i < 20 && busy; i++) tick();
        check("t4_drained", 64'(busy), 64'(0));
        check("t4_req_count", 64'(dut_req), 64'(2));
        check("t4_deliveries", 64'(dut_deliv), 64'(2));
        start = 1'b1;
        tick();
        check("t4_resume_valid", 64'(mem_req_valid), 64'(1));
        check("t4_resume_addr", 64'(mem_req_addr), 64'(32'h8));

        // 5: request held under backpressure, then pc wrap at the top of memory
        apply_reset();
        lat = 1; instr_ready = 1'b1; mem_req_ready = 1'b0; start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t5_hold_valid", 64'(mem_req_valid), 64'(1));
            check("t5_hold_addr", 64'(mem_req_addr), 64'(0));
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick();
        check("t5_aligned", 64'(mem_req_addr), 64'(32'hFFFF_FFFC));
        mem_req_ready = 1'b1;
        tick();
        check("t5_wrap", 64'(mem_req_addr), 64'(0));

        // 6: reset in the middle of random traffic
        apply_reset();
        lat = 2; start = 1'b1;
        tick();
        repeat (30) rand_cycle();
        apply_reset();
        repeat (3) tick();
        check("t6_idle_valid", 64'(mem_req_valid), 64'(0));
        check("t6_idle_addr", 64'(mem_req_addr), 64'(0));

        // Randomized soak with latency changes, jittered responses and redirects
        apply_reset();
        rsp_jitter = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) lat = $urandom_range(5, 1);
            rand_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
